// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: ID-stage operand info and EX branch in,
// stall/flush/forward controls out.
interface hazard_ctrl_if #(
    parameter int REG_AW = 4
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic              id_is_mem;
    logic              ex_pc_src;

    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              stall_m;
    logic              flush_d;
    logic              flush_e;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_is_load, id_is_mem, ex_pc_src,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               fwd_a, fwd_b, mem_busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_is_load, id_is_mem, ex_pc_src,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               fwd_a, fwd_b, mem_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit: shadow EX/MEM/WB tracking, data stalls, branch flush, memory wait.
// Build option: define HAZARD_FWD_EN to enable EX operand forwarding.
module hazard_ctrl #(
    parameter int REG_AW   = 4,
    parameter int MEM_WAIT = 0
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);

    // EX slot
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_is_load;
    logic              ex_is_mem;
`ifdef HAZARD_FWD_EN
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              ex_use_rs1;
    logic              ex_use_rs2;
    logic              mem_is_load;
`endif
    // MEM slot
    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic              mem_is_mem;
    // WB slot
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwrite;

    logic [2:0]        wait_cnt;
    logic              busy;
    logic              id_hit_ex;
    logic              id_hit_wb;
    logic              load_use;
    logic              data_stall;
    logic              front_stall;
    logic              bubble_e;

    function automatic logic src_hit(
        input logic              v,
        input logic              rw,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs1,
        input logic [REG_AW-1:0] rs2,
        input logic              u1,
        input logic              u2
    );
        return v && rw && ((u1 && (rd == rs1)) || (u2 && (rd == rs2)));
    endfunction

    assign busy = (wait_cnt != 3'd0);

    assign id_hit_ex = hz.id_valid && src_hit(ex_valid, ex_regwrite, ex_rd,
                                              hz.id_rs1, hz.id_rs2,
                                              hz.id_use_rs1, hz.id_use_rs2);
    assign id_hit_wb = hz.id_valid && src_hit(wb_valid, wb_regwrite, wb_rd,
                                              hz.id_rs1, hz.id_rs2,
                                              hz.id_use_rs1, hz.id_use_rs2);
    assign load_use  = id_hit_ex && ex_is_load;

`ifdef HAZARD_FWD_EN
    logic mem_fwd_a;
    logic mem_fwd_b;
    logic wb_fwd_a;
    logic wb_fwd_b;

    // Register file is not write-through, so a WB-slot producer cannot reach ID.
    assign data_stall = load_use || id_hit_wb;

    assign mem_fwd_a = ex_valid && ex_use_rs1 && mem_valid && mem_regwrite &&
                       !mem_is_load && (mem_rd == ex_rs1);
    assign mem_fwd_b = ex_valid && ex_use_rs2 && mem_valid && mem_regwrite &&
                       !mem_is_load && (mem_rd == ex_rs2);
    assign wb_fwd_a  = ex_valid && ex_use_rs1 && wb_valid && wb_regwrite &&
                       (wb_rd == ex_rs1);
    assign wb_fwd_b  = ex_valid && ex_use_rs2 && wb_valid && wb_regwrite &&
                       (wb_rd == ex_rs2);

    assign hz.fwd_a = mem_fwd_a ? 2'b01 : (wb_fwd_a ? 2'b10 : 2'b00);
    assign hz.fwd_b = mem_fwd_b ? 2'b01 : (wb_fwd_b ? 2'b10 : 2'b00);
`else
    logic id_hit_mem;

    assign id_hit_mem = hz.id_valid && src_hit(mem_valid, mem_regwrite, mem_rd,
                                               hz.id_rs1, hz.id_rs2,
                                               hz.id_use_rs1, hz.id_use_rs2);
    assign data_stall = load_use || id_hit_ex || id_hit_mem || id_hit_wb;
    assign hz.fwd_a   = 2'b00;
    assign hz.fwd_b   = 2'b00;
`endif

    // Wait beats dominate; a taken branch overrides any data stall.
    assign front_stall = busy || (data_stall && !hz.ex_pc_src);
    assign bubble_e    = !busy && (hz.ex_pc_src || data_stall);

    assign hz.stall_f  = front_stall;
    assign hz.stall_d  = front_stall;
    assign hz.stall_e  = busy;
    assign hz.stall_m  = busy;
    assign hz.flush_d  = !busy && hz.ex_pc_src;
    assign hz.flush_e  = bubble_e;
    assign hz.mem_busy = busy;

    // The counter loads on the edge the access leaves MEM, so the same
    // instruction is never seen in MEM again with a zero count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (busy) begin
            wait_cnt <= wait_cnt - 3'd1;
        end else if ((MEM_WAIT != 0) && mem_valid && mem_is_mem) begin
            wait_cnt <= 3'(MEM_WAIT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_is_mem    <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_is_mem   <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
`ifdef HAZARD_FWD_EN
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_use_rs1   <= 1'b0;
            ex_use_rs2   <= 1'b0;
            mem_is_load  <= 1'b0;
`endif
        end else if (!busy) begin
            wb_valid     <= mem_valid;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            mem_is_mem   <= ex_is_mem;
            ex_valid     <= hz.id_valid && !bubble_e;
            ex_rd        <= hz.id_rd;
            ex_regwrite  <= hz.id_regwrite;
            ex_is_load   <= hz.id_is_load;
            ex_is_mem    <= hz.id_is_mem;
`ifdef HAZARD_FWD_EN
            mem_is_load  <= ex_is_load;
            ex_rs1       <= hz.id_rs1;
            ex_rs2       <= hz.id_rs2;
            ex_use_rs1   <= hz.id_use_rs1;
            ex_use_rs2   <= hz.id_use_rs2;
`endif
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: one instance with MEM_WAIT=0,
// one with MEM_WAIT=3, driven with identical ID-stage stimulus.
module tb_hazard_ctrl;
    localparam int AW = 4;

    // Output vector: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_busy, fwd_a, fwd_b}
    localparam logic [10:0] Z    = 11'b00000000000;
    localparam logic [10:0] DST  = 11'b11000100000;
    localparam logic [10:0] BUSY = 11'b11110010000;
    localparam logic [10:0] BR   = 11'b00001100000;
    localparam logic [10:0] FA01 = 11'b00000000100;
    localparam logic [10:0] FB01 = 11'b00000000001;
    localparam logic [10:0] FA10 = 11'b00000001000;
    localparam logic [10:0] F10S = 11'b00000001010;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(AW)) bus0 ();
    hazard_ctrl_if #(.REG_AW(AW)) bus3 ();

    hazard_ctrl #(.REG_AW(AW), .MEM_WAIT(0)) dut0 (.clk(clk), .rst(rst), .hz(bus0.slave));
    hazard_ctrl #(.REG_AW(AW), .MEM_WAIT(3)) dut3 (.clk(clk), .rst(rst), .hz(bus3.slave));

    logic [10:0] out0;
    logic [10:0] out3;
    assign out0 = {bus0.stall_f, bus0.stall_d, bus0.stall_e, bus0.stall_m, bus0.flush_d,
                   bus0.flush_e, bus0.mem_busy, bus0.fwd_a, bus0.fwd_b};
    assign out3 = {bus3.stall_f, bus3.stall_d, bus3.stall_e, bus3.stall_m, bus3.flush_d,
                   bus3.flush_e, bus3.mem_busy, bus3.fwd_a, bus3.fwd_b};

    typedef struct {
        string       tag;
        bit          sel;
        logic [10:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   failed = 0;

    task automatic want(input string tag, input bit sel, input logic [10:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic score();
        exp_t        x;
        logic [10:0] o;
        while (sb.size() != 0) begin
            x = sb.pop_front();
            o = x.sel ? out3 : out0;
            checks++;
            assert (o === x.exp) passed++;
            else begin
                failed++;
                $error("FAIL %s (dut%0d): observed %b expected %b", x.tag, x.sel ? 3 : 0, o, x.exp);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        score();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic u1, input logic u2, input logic [AW-1:0] rd,
                          input logic rw, input logic ld, input logic mm);
        bus0.id_valid = v;   bus3.id_valid = v;
        bus0.id_rs1 = rs1;   bus3.id_rs1 = rs1;
        bus0.id_rs2 = rs2;   bus3.id_rs2 = rs2;
        bus0.id_use_rs1 = u1; bus3.id_use_rs1 = u1;
        bus0.id_use_rs2 = u2; bus3.id_use_rs2 = u2;
        bus0.id_rd = rd;     bus3.id_rd = rd;
        bus0.id_regwrite = rw; bus3.id_regwrite = rw;
        bus0.id_is_load = ld;  bus3.id_is_load = ld;
        bus0.id_is_mem = mm;   bus3.id_is_mem = mm;
    endtask

    task automatic id_nop();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic id_alu(input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2, input logic u1, input logic u2);
        set_id(1'b1, rs1, rs2, u1, u2, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic id_load(input logic [AW-1:0] rd, input logic [AW-1:0] rs1);
        set_id(1'b1, rs1, 4'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic id_store(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        set_id(1'b1, rs1, rs2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pc(input logic t);
        bus0.ex_pc_src = t;
        bus3.ex_pc_src = t;
    endtask

    task automatic idle(input int n);
        id_nop();
        pc(1'b0);
        repeat (n) cyc();
    endtask

    initial begin
        rst = 1'b1;
        pc(1'b0);
        id_nop();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        want("reset", 0, Z); want("reset", 1, Z); cyc();
        set_id(1'b0, 4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
        want("idle_invalid", 0, Z); want("idle_invalid", 1, Z); cyc();
        idle(2);

        // ADD r3 then ADD r4,r3,r1
        id_alu(4'd3, 4'd1, 4'd2, 1'b1, 1'b1); want("add_prod", 0, Z); cyc();
        id_alu(4'd4, 4'd3, 4'd1, 1'b1, 1'b1);
`ifdef HAZARD_FWD_EN
        want("add_nostall", 0, Z); cyc();
        id_nop(); want("add_fwd_a01", 0, FA01); cyc();
`else
        for (int i = 0; i < 3; i++) begin
            want("add_stall", 0, DST); cyc();
        end
        want("add_release", 0, Z); cyc();
        id_nop(); want("add_fwd_none", 0, Z); cyc();
`endif
        idle(3);

        // r0 is an ordinary register; only rs2 is actually read
        id_alu(4'd0, 4'd5, 4'd6, 1'b1, 1'b1); want("r0_prod", 0, Z); cyc();
        id_alu(4'd7, 4'd0, 4'd0, 1'b0, 1'b1);
`ifdef HAZARD_FWD_EN
        want("r0_nostall", 0, Z); cyc();
        id_nop(); want("r0_fwd_b01", 0, FB01); cyc();
`else
        want("r0_stall", 0, DST); cyc();
`endif
        idle(3);

        // LOAD r2 then SUB r5,r2,r2
        id_load(4'd2, 4'd7); want("ld_prod", 0, Z); cyc();
        id_alu(4'd5, 4'd2, 4'd2, 1'b1, 1'b1);
        want("ld_use_stall", 0, DST); cyc();
`ifdef HAZARD_FWD_EN
        want("ld_one_stall", 0, Z); cyc();
        id_nop(); want("ld_fwd_wb", 0, F10S); cyc();
`else
        want("ld_mem_stall", 0, DST); cyc();
        want("ld_wb_stall", 0, DST); cyc();
        want("ld_release", 0, Z); cyc();
        id_nop(); want("ld_fwd_none", 0, Z); cyc();
`endif
        idle(3);

        // Branch taken while ID holds a load-use consumer
        id_load(4'd2, 4'd7); want("br_ld", 0, Z); cyc();
        id_alu(4'd5, 4'd2, 4'd2, 1'b1, 1'b1); pc(1'b1);
        want("br_over_stall", 0, BR); cyc();
        pc(1'b0); id_nop(); want("br_after", 0, Z); cyc();
        idle(3);

        // Producer in WB while consumer sits in ID
        id_alu(4'd6, 4'd1, 4'd2, 1'b1, 1'b1); want("wb_prod", 0, Z); cyc();
        id_nop(); want("wb_gap1", 0, Z); cyc();
        want("wb_gap2", 0, Z); cyc();
        id_alu(4'd8, 4'd6, 4'd6, 1'b1, 1'b1); want("wb_stall", 0, DST); cyc();
        want("wb_release", 0, Z); cyc();
        idle(3);

        rst = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        want("reset2", 1, Z); cyc();

        // Store with MEM_WAIT=3; ADD r9 behind it must stay frozen in MEM
        id_store(4'd1, 4'd2); want("st_id", 1, Z); cyc();
        id_alu(4'd9, 4'd1, 4'd1, 1'b1, 1'b0); want("st_ex", 1, Z); cyc();
        id_nop(); want("st_mem", 1, Z); cyc();
        id_alu(4'd10, 4'd9, 4'd9, 1'b1, 1'b0);
        want("st_busy1", 1, BUSY);
`ifdef HAZARD_FWD_EN
        want("st_nowait", 0, Z);
`else
        want("st_nowait", 0, DST);
`endif
        cyc();
        want("st_busy2", 1, BUSY); cyc();
        want("st_busy3", 1, BUSY); cyc();
`ifdef HAZARD_FWD_EN
        want("st_end", 1, Z); cyc();
        id_nop(); want("st_frozen_fwd", 1, FA10); cyc();
`else
        want("st_end", 1, DST); cyc();
        want("st_frozen_wb", 1, DST); cyc();
        want("st_release", 1, Z); cyc();
`endif
        idle(3);
        want("st_single", 1, Z); cyc();

        // Branch during wait is deferred to the first free cycle
        id_store(4'd3, 4'd4); want("bw_id", 1, Z); cyc();
        id_nop(); want("bw_ex", 1, Z); cyc();
        want("bw_mem", 1, Z); cyc();
        pc(1'b1);
        for (int i = 0; i < 3; i++) begin
            want("bw_busy", 1, BUSY); cyc();
        end
        want("bw_flush", 1, BR); cyc();
        pc(1'b0); want("bw_done", 1, Z); cyc();
        idle(2);

        // Reset pulsed while the counter holds 2
        id_store(4'd5, 4'd6); cyc();
        id_nop(); cyc();
        cyc();
        want("rw_busy3", 1, BUSY); cyc();
        want("rw_busy2", 1, BUSY);
        #1 score();
        rst = 1'b1;
        #2;
        want("rw_async", 1, Z); want("rw_async", 0, Z);
        score();
        @(posedge clk); #1;
        rst = 1'b0;
        want("rw_release", 1, Z); cyc();
        want("rw_after", 1, Z); cyc();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
